// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map and the word-splitting helper used by the
// frame decoder.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } word_t;

  // Only the low 12 bits of a 16-bit word carry meaning.
  function automatic word_t split_word(input logic [11:0] w);
    word_t r;
    r.addr = w[11:8];
    r.data = w[7:0];
    return r;
  endfunction

  function automatic logic is_digit(input logic [3:0] a);
    return (a >= REG_DIGIT0) && (a <= REG_DIGIT7);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus rising-edge
// detection on the synchronized copy.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      prev <= pipe[STAGES-1];
    end
  end

  assign q    = pipe[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/max7219_frame_capture.sv
// Snoops a cascaded MAX7219 serial link and mirrors the digit rows,
// shutdown and display-test state of every device in the chain.
module max7219_frame_capture
  import max7219_pkg::*;
#(
  parameter  int CHAIN_LEN   = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int DEV_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 max_cs,
  input  logic                 max_clk,
  input  logic                 max_data,
  input  logic [DEV_W-1:0]     rd_dev,
  input  logic [2:0]           rd_row,
  output logic [7:0]           rd_data,
  output logic [CHAIN_LEN-1:0] shutdown,
  output logic [CHAIN_LEN-1:0] disp_test,
  output logic                 frame_valid,
  output logic                 frame_err
);

  localparam int FRAME_BITS = CHAIN_LEN * 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [DEV_W:0]   DEV_LIMIT = (DEV_W + 1)'(CHAIN_LEN);

  logic cs_q, cs_rise, clk_q, clk_rise, data_q, data_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(max_cs), .q(cs_q), .rise(cs_rise));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .din(max_clk), .q(clk_q), .rise(clk_rise));
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst(rst), .din(max_data), .q(data_q), .rise(data_rise_unused));

  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  shift_en, commit, reject;
  logic                  msb_unused;

  // A serial clock edge while CS is high never shifts, which also covers
  // the cycle in which the CS rising edge itself is seen.
  assign shift_en   = clk_rise & ~cs_q;
  assign commit     = cs_rise & (bit_cnt == CNT_FULL);
  assign reject     = cs_rise & (bit_cnt != CNT_FULL);
  assign msb_unused = sr[FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (cs_rise) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr <= {sr[FRAME_BITS-2:0], data_q};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // The word shifted last sits at the bottom and belongs to device 0.
  word_t dev_word [CHAIN_LEN];

  always_comb begin
    for (int d = 0; d < CHAIN_LEN; d++) dev_word[d] = split_word(sr[16*d +: 12]);
  end

  logic [7:0] fb [CHAIN_LEN][8];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < CHAIN_LEN; d++)
        for (int r = 0; r < 8; r++) fb[d][r] <= '0;
      shutdown    <= '1;
      disp_test   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_err   <= reject;
      if (commit) begin
        for (int d = 0; d < CHAIN_LEN; d++) begin
          if (is_digit(dev_word[d].addr))
            fb[d][3'(dev_word[d].addr - 4'd1)] <= dev_word[d].data;
          else if (dev_word[d].addr == REG_SHUTDOWN)
            shutdown[d] <= ~dev_word[d].data[0];
          else if (dev_word[d].addr == REG_TEST)
            disp_test[d] <= dev_word[d].data[0];
        end
      end
    end
  end

  // Registered read; a same-cycle commit lands after the read samples.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if ({1'b0, rd_dev} < DEV_LIMIT)
      rd_data <= fb[rd_dev][rd_row];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_max7219_frame_capture.sv
// Randomized self-checking bench: serial frames are bit-banged onto the
// link and results compared with a register-map level model.
module tb_max7219_frame_capture;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, max_cs, max_clk, max_data;
  logic [1:0]   rd_dev;
  logic [2:0]   rd_row;
  logic [7:0]   rd_data;
  logic [N-1:0] shutdown, disp_test;
  logic         frame_valid, frame_err;

  max7219_frame_capture #(.CHAIN_LEN(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .max_cs(max_cs), .max_clk(max_clk), .max_data(max_data),
    .rd_dev(rd_dev), .rd_row(rd_row), .rd_data(rd_data), .shutdown(shutdown),
    .disp_test(disp_test), .frame_valid(frame_valid), .frame_err(frame_err));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int valid_cnt = 0, err_cnt = 0, exp_valid = 0, exp_err = 0;

  logic [7:0]   m_fb [N][8];
  logic [N-1:0] m_sd, m_dt;

  always @(negedge clk) begin
    if (frame_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    max_data = b;
    cycles(2);
    max_clk = 1'b1;
    cycles(3);
    max_clk = 1'b0;
    cycles(2);
  endtask

  task automatic send_bits(input int n, input logic [127:0] v);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input int n, input logic [127:0] v);
    max_cs = 1'b0;
    cycles(3);
    send_bits(n, v);
    max_cs = 1'b1;
    cycles(8);
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) m_fb[d][r] = 8'h00;
    m_sd = '1;
    m_dt = '0;
  endtask

  task automatic model_word(input int dev, input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    if (a >= 1 && a <= 8) m_fb[dev][a-1] = w[7:0];
    else if (a == 12) m_sd[dev] = ~w[0];
    else if (a == 15) m_dt[dev] = w[0];
  endtask

  // Word k (first on the wire) addresses device N-1-k.
  task automatic model_frame(input logic [63:0] words);
    for (int k = 0; k < N; k++) model_word(N - 1 - k, words[63 - 16*k -: 16]);
  endtask

  task automatic read_byte(input int d, input int r, output logic [7:0] v);
    rd_dev = 2'(d);
    rd_row = 3'(r);
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  function automatic logic [63:0] rand_words();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    model_reset();
    n_checks++;
    if (shutdown !== 4'b1111) begin
      n_fail++; $display("FAIL reset_shutdown: got %b expected 1111", shutdown);
    end
    n_checks++;
    if (disp_test !== 4'b0000) begin
      n_fail++; $display("FAIL reset_disp_test: got %b expected 0000", disp_test);
    end
    n_checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got v=%b e=%b expected 0 0", frame_valid, frame_err);
    end
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== 8'h00) begin
          n_fail++; $display("FAIL reset_buf[%0d][%0d]: got %h expected 00", d, r, v);
        end
      end
  endtask

  task automatic test_single_frame();
    logic [63:0] w;
    logic [7:0]  v;
    w = {16'h0C01, 16'h0C01, 16'h0C01, 16'h01A5};
    send_frame(64, {64'h0, w});
    model_frame(w);
    exp_valid++;
    n_checks++;
    if (valid_cnt !== exp_valid || err_cnt !== exp_err) begin
      n_fail++; $display("FAIL single_pulses: got v=%0d e=%0d expected v=%0d e=%0d",
                         valid_cnt, err_cnt, exp_valid, exp_err);
    end
    n_checks++;
    if (shutdown !== m_sd) begin
      n_fail++; $display("FAIL single_shutdown: got %b expected %b", shutdown, m_sd);
    end
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== m_fb[d][r]) begin
          n_fail++; $display("FAIL single_buf[%0d][%0d]: got %h expected %h", d, r, v, m_fb[d][r]);
        end
      end
  endtask

  task automatic test_shutdown_test();
    logic [63:0] w;
    w = {4{16'h0C01}};
    send_frame(64, {64'h0, w});
    model_frame(w);
    exp_valid++;
    n_checks++;
    if (shutdown !== m_sd) begin
      n_fail++; $display("FAIL sd_all: got %b expected %b", shutdown, m_sd);
    end
    w = {16'h0F01, 16'h0000, 16'h0000, 16'h0000};
    send_frame(64, {64'h0, w});
    model_frame(w);
    exp_valid++;
    n_checks++;
    if (disp_test !== m_dt || shutdown !== m_sd) begin
      n_fail++; $display("FAIL disp_test: got dt=%b sd=%b expected dt=%b sd=%b",
                         disp_test, shutdown, m_dt, m_sd);
    end
    n_checks++;
    if (valid_cnt !== exp_valid) begin
      n_fail++; $display("FAIL sd_valid_cnt: got %0d expected %0d", valid_cnt, exp_valid);
    end
  endtask

  task automatic test_bad_length();
    logic [7:0] v;
    send_frame(48, {$urandom, $urandom, $urandom, $urandom});
    send_frame(80, {$urandom, $urandom, $urandom, $urandom});
    exp_err += 2;
    n_checks++;
    if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
      n_fail++; $display("FAIL bad_len_pulses: got v=%0d e=%0d expected v=%0d e=%0d",
                         valid_cnt, err_cnt, exp_valid, exp_err);
    end
    n_checks++;
    if (shutdown !== m_sd || disp_test !== m_dt) begin
      n_fail++; $display("FAIL bad_len_ctrl: got sd=%b dt=%b expected sd=%b dt=%b",
                         shutdown, disp_test, m_sd, m_dt);
    end
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== m_fb[d][r]) begin
          n_fail++; $display("FAIL bad_len_buf[%0d][%0d]: got %h expected %h", d, r, v, m_fb[d][r]);
        end
      end
  endtask

  task automatic test_rows();
    logic [63:0] w;
    logic [7:0]  v;
    for (int r = 1; r <= 8; r++) begin
      for (int k = 0; k < N; k++)
        w[63 - 16*k -: 16] = {4'h0, 4'(r), 4'(N - 1 - k), 4'(r - 1)};
      send_frame(64, {64'h0, w});
      model_frame(w);
      exp_valid++;
    end
    n_checks++;
    if (valid_cnt !== exp_valid) begin
      n_fail++; $display("FAIL rows_valid_cnt: got %0d expected %0d", valid_cnt, exp_valid);
    end
    // Consecutive reads: each address's data arrives exactly one edge later.
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== {4'(d), 4'(r)}) begin
          n_fail++; $display("FAIL rows_buf[%0d][%0d]: got %h expected %h", d, r, v, {4'(d), 4'(r)});
        end
      end
  endtask

  task automatic test_collision();
    logic [63:0] w;
    logic [7:0]  old_v, new_v;
    bit          seen;
    old_v = m_fb[0][2];
    new_v = old_v ^ 8'($urandom_range(1, 255));
    w = {16'h0000, 16'h0000, 16'h0000, 8'h03, new_v};
    rd_dev = 2'd0;
    rd_row = 3'd2;
    max_cs = 1'b0;
    cycles(3);
    send_bits(64, {64'h0, w});
    max_cs = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycles(1);
      if (frame_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (rd_data !== old_v) begin
          n_fail++; $display("FAIL collision_old: got %h expected %h", rd_data, old_v);
        end
        cycles(1);
        n_checks++;
        if (rd_data !== new_v) begin
          n_fail++; $display("FAIL collision_new: got %h expected %h", rd_data, new_v);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL collision_timeout: got no frame_valid expected pulse within 30 cycles");
    end
    model_frame(w);
    exp_valid++;
    cycles(4);
  endtask

  task automatic test_random();
    logic [63:0] w;
    logic [7:0]  v;
    int          len;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(65, 100));
        send_frame(len, {$urandom, $urandom, $urandom, $urandom});
        exp_err++;
      end else begin
        w = rand_words();
        send_frame(64, {64'h0, w});
        model_frame(w);
        exp_valid++;
      end
    end
    n_checks++;
    if (valid_cnt !== exp_valid || err_cnt !== exp_err) begin
      n_fail++; $display("FAIL rand_pulses: got v=%0d e=%0d expected v=%0d e=%0d",
                         valid_cnt, err_cnt, exp_valid, exp_err);
    end
    n_checks++;
    if (shutdown !== m_sd || disp_test !== m_dt) begin
      n_fail++; $display("FAIL rand_ctrl: got sd=%b dt=%b expected sd=%b dt=%b",
                         shutdown, disp_test, m_sd, m_dt);
    end
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== m_fb[d][r]) begin
          n_fail++; $display("FAIL rand_buf[%0d][%0d]: got %h expected %h", d, r, v, m_fb[d][r]);
        end
      end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] w;
    logic [7:0]  v;
    w = {16'h0111, 16'h0222, 16'h0333, 16'h0444};
    max_cs = 1'b0;
    cycles(3);
    send_bits(20, {64'h0, w[63:44]});
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    model_reset();
    send_bits(44, {84'h0, w[43:0]});
    max_cs = 1'b1;
    cycles(8);
    exp_err++;
    n_checks++;
    if (err_cnt !== exp_err || valid_cnt !== exp_valid) begin
      n_fail++; $display("FAIL midrst_pulses: got v=%0d e=%0d expected v=%0d e=%0d",
                         valid_cnt, err_cnt, exp_valid, exp_err);
    end
    n_checks++;
    if (shutdown !== m_sd || disp_test !== m_dt) begin
      n_fail++; $display("FAIL midrst_ctrl: got sd=%b dt=%b expected sd=%b dt=%b",
                         shutdown, disp_test, m_sd, m_dt);
    end
    for (int d = 0; d < N; d++)
      for (int r = 0; r < 8; r++) begin
        read_byte(d, r, v);
        n_checks++;
        if (v !== 8'h00) begin
          n_fail++; $display("FAIL midrst_buf[%0d][%0d]: got %h expected 00", d, r, v);
        end
      end
  endtask

  initial begin
    rst      = 1'b1;
    max_cs   = 1'b1;
    max_clk  = 1'b0;
    max_data = 1'b0;
    rd_dev   = 2'd0;
    rd_row   = 3'd0;
    test_reset();
    test_single_frame();
    test_shutdown_test();
    test_bad_length();
    test_rows();
    test_collision();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
